// File: rtl/imem_loader.sv
// Instruction memory loader: streams 32-bit words over valid/ready into consecutive
// word addresses from BASE_ADDR and holds the CPU in reset until a load completes.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned CNT_W       = $clog2(DEPTH_WORDS + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  input  logic             reload,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic [CNT_W-1:0] word_count,
  output logic             cpu_hold,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH_WORDS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(DEPTH_WORDS);

  state_t           state, state_n;
  logic             xfer;
  logic [CNT_W-1:0] count_n;

  always_comb begin
    in_ready = (state == S_LOAD);
    xfer     = in_valid & in_ready;
    state_n  = state;
    count_n  = word_count;
    case (state)
      S_LOAD: begin
        if (xfer) begin
          if (word_count != MAX_CNT) count_n = word_count + 1'b1;
          if (in_last)                    state_n = S_DONE;
          else if (word_count == LAST_IDX) state_n = S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (reload) begin
          state_n = S_LOAD;
          count_n = '0;
        end
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= S_LOAD;
      word_count <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      word_count <= count_n;
      imem_we    <= xfer;
      if (xfer) begin
        imem_addr  <= BASE_ADDR + 32'({word_count, 2'b00});
        imem_wdata <= in_data;
      end
      done     <= (state_n == S_DONE);
      overflow <= (state_n == S_ERROR);
      // Final word enters DONE together with its write; release only once that write has issued.
      cpu_hold <= (state_n != S_DONE) || xfer;
    end
  end

endmodule
